fc_input_packer: RTL
====================

Name: fc_input_packer

Overview:
- Sits directly upstream of the fully-connected stage and feeds its packed 8-lane int8 input vector.
- Accepts a stream of signed 16-bit pooled activations through a valid/ready handshake.
- Applies ReLU, then an arithmetic right-shift requantization, then saturation to int8.
- Packs 8 results into the 64-bit vector, pulses the FC enable, and holds the vector stable until the FC stage reports done.

Parameters:
- N_LANES, 8, activations per packed vector.
- IN_W, 16, input activation width (signed).
- OUT_W, 8, packed lane width (signed int8).
- SHIFT, 4, requantization right-shift amount (0..IN_W-1).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- in_data  in  IN_W  signed activation.
- in_valid  in  1  in_data valid.
- in_last  in  1  last activation of a frame; qualified by in_valid.
- in_ready  out  1  packer can accept.
- fc_input  out  N_LANES*OUT_W  packed vector; lane k at bits [8k+7:8k].
- fc_enable  out  1  one-cycle start pulse to the FC stage.
- fc_done  in  1  FC stage result registered.
- busy  out  1  high in ISSUE or WAIT.
- sat_count  out  8  saturating count of clipped activations since reset.

Behaviour:
- Reset (async, rst_n=0): state=FILL, lane counter=0, fc_input=0, fc_enable=0, busy=0, sat_count=0, in_ready=1 once rst_n deasserts.
- Transfer occurs when in_valid && in_ready on a rising edge.
- Per-transfer datapath, combinational then registered into lane[cnt]:
  - r = (in_data<0) ? 0 : in_data.
  - s = r >>> SHIFT.
  - q = (s>127) ? 127 : s[7:0].
  - Saturation (s>127) increments sat_count, which holds at 255. A negative input is not counted as saturation.
- States:
  - FILL: in_ready=1. Each transfer writes lane[cnt] and increments cnt.
    - The transfer with cnt==N_LANES-1, or with in_last=1, moves the state to ISSUE.
    - On an early in_last, lanes cnt+1..N_LANES-1 are zeroed in the same edge.
    - cnt resets to 0 on leaving FILL.
  - ISSUE: one cycle. fc_enable=1, in_ready=0, busy=1. Next state is WAIT.
  - WAIT: fc_enable=0, in_ready=0, busy=1. fc_input is held constant. fc_done=1 moves the state to FILL, and in_ready=1 in the following cycle.
- Latency: the 8th accepted activation at edge N gives fc_enable high during cycle N+1, with fc_input already valid in that cycle.
- fc_input is updated lane-by-lane only in FILL. It must not change from the ISSUE cycle until the fc_done edge.
- fc_done outside WAIT is ignored.
- fc_done arriving on the ISSUE cycle is ignored, because the FC stage cannot finish in zero cycles.
- in_last with in_valid=0 has no effect.
- A single-element frame (in_last on the first transfer) gives lane0=q and lanes 1..7=0.
- Reset asserted mid-frame or in WAIT aborts:
  - Partial lanes are discarded and fc_input is cleared.
  - No fc_enable is emitted after reset release until a new vector fills.
- A frame longer than N_LANES splits into successive vectors. in_last applies only to the vector in which it arrives.

Decomposition:
- Shared package ml_accel_pkg holds:
  - ACT_W=16 and Q_W=8.
  - FC_LANES=8.
  - The state enum {FILL, ISSUE, WAIT}.
  - Q_MAX=127.
- One sub-module: relu_requant (combinational ReLU, shift and saturate, plus a sat flag). It is reusable by the conv stage.
- The FSM, lane registers and counters stay in fc_input_packer.

Test Plan:
- Full vector: stream 16, 32, 48, 64, 80, 96, 112, 128 (SHIFT=4), with fc_done returned 3 cycles after fc_enable.
  - Expect fc_input=0x0807060504030201.
  - Expect fc_enable high exactly 1 cycle, one cycle after the 8th transfer.
  - Expect in_ready low until the cycle after fc_done.
- ReLU/saturation: inputs -5, 0, 2047, 2048, 4000, -32768, 32767, 15.
  - Expect lanes 0, 0, 127, 127, 127, 0, 127, 0.
  - Expect sat_count=3.
- Early last: 3 transfers 0x0010, 0x0020, 0x0030 with in_last on the 3rd.
  - Expect fc_input=0x0000000000030201 and a single fc_enable pulse.
- Backpressure/stability: hold in_valid=1 throughout, delay fc_done by 20 cycles.
  - Expect no transfers during busy.
  - Expect fc_input unchanged for those 20 cycles.
  - The 9th input must land in lane 0 of the next vector.
- Reset mid-operation: assert rst_n=0 asynchronously (between clock edges) after 5 transfers, then again in WAIT.
  - Expect immediate fc_input=0, busy=0, sat_count=0.
  - After release, 8 new inputs produce exactly one fc_enable.
- Spurious done: pulse fc_done during FILL and on the ISSUE cycle.
  - Expect no state change.
  - Expect WAIT to exit only on a later fc_done.

Source files
------------

// File: rtl/ml_accel_pkg.sv
// Shared widths, lane count and packer state encoding for the ML accelerator datapath.
package ml_accel_pkg;

  localparam int unsigned ACT_W    = 16;
  localparam int unsigned Q_W      = 8;
  localparam int unsigned FC_LANES = 8;
  localparam int unsigned Q_MAX    = 127;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } pack_state_e;

endpackage

// File: rtl/relu_requant.sv
// Combinational ReLU, arithmetic right-shift requantization and saturation to signed int8.
module relu_requant
  import ml_accel_pkg::*;
#(
  parameter int unsigned IN_W  = ACT_W,
  parameter int unsigned OUT_W = Q_W,
  parameter int unsigned SHIFT = 4
) (
  input  logic [IN_W-1:0]  in_data,
  output logic [OUT_W-1:0] q_c,
  output logic             sat_c
);

  localparam logic [IN_W-1:0] QMAX_EXT = IN_W'(Q_MAX);

  logic [IN_W-1:0] relu;
  logic [IN_W-1:0] shifted;

  // After ReLU the value is non-negative, so a logical shift equals the arithmetic one.
  always_comb begin
    relu    = in_data[IN_W-1] ? '0 : in_data;
    shifted = relu >> SHIFT;
    sat_c   = (shifted > QMAX_EXT);
    q_c     = sat_c ? OUT_W'(Q_MAX) : shifted[OUT_W-1:0];
  end

endmodule

// File: rtl/fc_input_packer.sv
// Packs requantized activations into an 8-lane int8 vector and hands it to the FC stage.
module fc_input_packer
  import ml_accel_pkg::*;
#(
  parameter int unsigned N_LANES = FC_LANES,
  parameter int unsigned IN_W    = ACT_W,
  parameter int unsigned OUT_W   = Q_W,
  parameter int unsigned SHIFT   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [IN_W-1:0]          in_data,
  input  logic                     in_valid,
  input  logic                     in_last,
  output logic                     in_ready,
  output logic [N_LANES*OUT_W-1:0] fc_input,
  output logic                     fc_enable,
  input  logic                     fc_done,
  output logic                     busy,
  output logic [7:0]               sat_count
);

  localparam int unsigned CNT_W = (N_LANES > 1) ? $clog2(N_LANES) : 1;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(N_LANES - 1);

  pack_state_e      state;
  logic [CNT_W-1:0] cnt;
  logic [OUT_W-1:0] q_c;
  logic             sat_c;
  logic             xfer_c;

  relu_requant #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_requant (
    .in_data (in_data),
    .q_c     (q_c),
    .sat_c   (sat_c)
  );

  assign xfer_c = in_valid && in_ready;

  // FSM, lane registers and saturation counter; outputs are registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FILL;
      cnt       <= '0;
      fc_input  <= '0;
      fc_enable <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
      sat_count <= '0;
    end else begin
      fc_enable <= 1'b0;
      case (state)
        FILL: begin
          if (xfer_c) begin
            // Write the current lane; an early last clears the lanes above it.
            for (int unsigned k = 0; k < N_LANES; k++) begin
              if (CNT_W'(k) == cnt) begin
                fc_input[k*OUT_W +: OUT_W] <= q_c;
              end else if (in_last && (CNT_W'(k) > cnt)) begin
                fc_input[k*OUT_W +: OUT_W] <= '0;
              end
            end
            if (sat_c && (sat_count != 8'hFF)) begin
              sat_count <= sat_count + 8'd1;
            end
            if (in_last || (cnt == LAST_LANE)) begin
              state     <= ISSUE;
              cnt       <= '0;
              fc_enable <= 1'b1;
              busy      <= 1'b1;
              in_ready  <= 1'b0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        ISSUE: begin
          state <= WAIT;
        end
        WAIT: begin
          if (fc_done) begin
            state    <= FILL;
            busy     <= 1'b0;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state    <= FILL;
          cnt      <= '0;
          busy     <= 1'b0;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
